// File: rtl/fec_decode_engine.sv
// fec_decode_engine
// Hamming(16,11) SECDED decoder acting as a second master on data memory.
// Reads NUM_WORDS codewords (high byte first) starting at IN_BASE, corrects
// single-bit errors, flags double-bit errors and writes a 2-byte result
// {flags, 3'b000, d11..d9} / {d8..d1} per word starting at OUT_BASE.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   start      level request; a run launches on the first clk after it falls
//   done       high while the engine sits in its finished state
//   mem_addr   byte address driven during memory accesses, 0 otherwise
//   mem_rd_en  read strobe (mem_rdata is valid in the same cycle)
//   mem_rdata  combinational read data from memory
//   mem_wr_en  write strobe (memory captures on the next clk edge)
//   mem_wdata  write data
//
// Optional feature macro: FEC_ERR_COUNT_EN
//   Adds err_single_cnt / err_double_cnt (8-bit, saturating) counting words
//   classified as corrected-single and detected-double during the last run.

module fec_decode_engine #(
  parameter int IN_BASE   = 30,
  parameter int OUT_BASE  = 0,
  parameter int NUM_WORDS = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  output logic [7:0] mem_addr,
  output logic       mem_rd_en,
  input  logic [7:0] mem_rdata,
  output logic       mem_wr_en,
  output logic [7:0] mem_wdata
`ifdef FEC_ERR_COUNT_EN
  ,
  output logic [7:0] err_single_cnt,
  output logic [7:0] err_double_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_RD_HI, S_RD_LO, S_DEC, S_WR_HI, S_WR_LO, S_DONE
  } state_t;

  // Codeword positions of d11..d1, packed 4 bits each with d1 in the low nibble.
  localparam logic [43:0] DPOS = {4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10,
                                  4'd9, 4'd7, 4'd6, 4'd5, 4'd3};

  state_t      state;
  logic [6:0]  idx;
  logic [7:0]  hi_in;
  logic [7:0]  lo_in;
  logic [7:0]  lo_q;

  logic [15:0] cw;
  logic [3:0]  syn;
  logic        parity;
  logic [1:0]  flags;
  logic [10:0] data_raw;
  logic [10:0] data_fix;
  logic [7:0]  dec_hi;
  logic [7:0]  dec_lo;

  logic [6:0]  next_idx;
  logic [7:0]  in_addr;
  logic [7:0]  next_in_addr;
  logic [7:0]  out_addr;
  logic        last_word;

  assign cw = {hi_in, lo_in};

  // Each syndrome bit is the parity over the positions whose index has that
  // bit set, which equals the XOR of the indices of all set bits.
  assign syn[0] = ^(cw & 16'hAAAA);
  assign syn[1] = ^(cw & 16'hCCCC);
  assign syn[2] = ^(cw & 16'hF0F0);
  assign syn[3] = ^(cw & 16'hFF00);
  assign parity = ^cw;

  assign flags = parity ? 2'b01 : ((syn != 4'd0) ? 2'b10 : 2'b00);

  assign data_raw = {cw[15:9], cw[7:5], cw[3]};

  // Only a data bit whose position matches the syndrome is flipped; an odd
  // parity with syn pointing at a parity bit (or at p0) leaves data untouched.
  always_comb begin
    data_fix = data_raw;
    for (int j = 0; j < 11; j++) begin
      data_fix[j] = data_raw[j] ^ (parity && (syn == DPOS[j*4 +: 4]));
    end
  end

  assign dec_lo = data_fix[7:0];
  assign dec_hi = {flags, 3'b000, data_fix[10:8]};

  assign next_idx     = idx + 7'd1;
  assign in_addr      = 8'(IN_BASE) + {idx, 1'b0};
  assign next_in_addr = 8'(IN_BASE) + {next_idx, 1'b0};
  assign out_addr     = 8'(OUT_BASE) + {idx, 1'b0};
  assign last_word    = (idx == 7'(NUM_WORDS - 1));

  // Outputs are registered: each transition loads the bus values that the
  // destination state must present, so non-access states default to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= 7'd0;
      hi_in     <= 8'd0;
      lo_in     <= 8'd0;
      lo_q      <= 8'd0;
      done      <= 1'b0;
      mem_addr  <= 8'd0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_wdata <= 8'd0;
`ifdef FEC_ERR_COUNT_EN
      err_single_cnt <= 8'd0;
      err_double_cnt <= 8'd0;
`endif
    end else begin
      mem_addr  <= 8'd0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_wdata <= 8'd0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ARM;
`ifdef FEC_ERR_COUNT_EN
            err_single_cnt <= 8'd0;
            err_double_cnt <= 8'd0;
`endif
          end
        end
        S_ARM: begin
          if (!start) begin
            state     <= S_RD_HI;
            mem_addr  <= in_addr;
            mem_rd_en <= 1'b1;
          end
        end
        S_RD_HI: begin
          hi_in     <= mem_rdata;
          state     <= S_RD_LO;
          mem_addr  <= in_addr + 8'd1;
          mem_rd_en <= 1'b1;
        end
        S_RD_LO: begin
          lo_in <= mem_rdata;
          state <= S_DEC;
        end
        S_DEC: begin
          lo_q      <= dec_lo;
          state     <= S_WR_HI;
          mem_addr  <= out_addr;
          mem_wr_en <= 1'b1;
          mem_wdata <= dec_hi;
`ifdef FEC_ERR_COUNT_EN
          if (flags == 2'b01 && err_single_cnt != 8'hFF)
            err_single_cnt <= err_single_cnt + 8'd1;
          if (flags == 2'b10 && err_double_cnt != 8'hFF)
            err_double_cnt <= err_double_cnt + 8'd1;
`endif
        end
        S_WR_HI: begin
          state     <= S_WR_LO;
          mem_addr  <= out_addr + 8'd1;
          mem_wr_en <= 1'b1;
          mem_wdata <= lo_q;
        end
        S_WR_LO: begin
          if (last_word) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            idx       <= next_idx;
            state     <= S_RD_HI;
            mem_addr  <= next_in_addr;
            mem_rd_en <= 1'b1;
          end
        end
        S_DONE: begin
          if (start) begin
            state <= S_ARM;
            done  <= 1'b0;
            idx   <= 7'd0;
`ifdef FEC_ERR_COUNT_EN
            err_single_cnt <= 8'd0;
            err_double_cnt <= 8'd0;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fec_decode_engine.sv
// tb_fec_decode_engine
// Self-checking bench for fec_decode_engine with default parameters
// (IN_BASE=30, OUT_BASE=0, NUM_WORDS=15). A byte-wide memory model answers
// the engine's bus; a decode model derived from the SECDED rules predicts
// every bus cycle of a run and the final memory image.

module tb_fec_decode_engine;

  localparam int IN  = 30;
  localparam int OUT = 0;
  localparam int NW  = 15;

  logic       clk;
  logic       reset;
  logic       start;
  logic       done;
  logic [7:0] mem_addr;
  logic       mem_rd_en;
  logic [7:0] mem_rdata;
  logic       mem_wr_en;
  logic [7:0] mem_wdata;
`ifdef FEC_ERR_COUNT_EN
  logic [7:0] err_single_cnt;
  logic [7:0] err_double_cnt;
`endif

  logic [7:0] mem [256];
  logic [7:0] exp_hi [NW];
  logic [7:0] exp_lo [NW];
  logic [7:0] snap [2*NW];
  int         exp_single;
  int         exp_double;
  int         dpos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  int errors;
  int checks;
  bit tracking;
  bit model_done;
  int run_n;

  fec_decode_engine dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata)
`ifdef FEC_ERR_COUNT_EN
    ,
    .err_single_cnt (err_single_cnt),
    .err_double_cnt (err_double_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory the engine masters: combinational read, edge-registered write.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Decode straight from the rules: syndrome as XOR of set positions,
  // overall parity by counting ones, then flip and gather data bits.
  function automatic logic [15:0] modelDecode(input logic [15:0] cw_in);
    logic [15:0] c;
    int s, ones, fl, data;
    c = cw_in;
    s = 0;
    ones = 0;
    for (int k = 0; k < 16; k++) begin
      if (c[k]) begin
        ones++;
        s = s ^ k;
      end
    end
    if (ones % 2 == 1) begin
      c[s] = ~c[s];
      fl = 1;
    end else if (s != 0) begin
      fl = 2;
    end else begin
      fl = 0;
    end
    data = 0;
    for (int j = 0; j < 11; j++) begin
      if (c[dpos[j]]) data = data + (1 << j);
    end
    return {fl[1:0], 3'b000, data[10:8], data[7:0]};
  endfunction

  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] c;
    logic par;
    c = 16'h0000;
    for (int j = 0; j < 11; j++) c[dpos[j]] = d[j];
    for (int p = 1; p <= 8; p = p * 2) begin
      par = 1'b0;
      for (int k = 1; k < 16; k++) begin
        if ((k & p) != 0) par = par ^ c[k];
      end
      c[p] = par;
    end
    c[0] = ^c[15:1];
    return c;
  endfunction

  function automatic logic [15:0] randomCodeword();
    logic [15:0] c;
    int nf, b1, b2;
    c = encode(11'($urandom));
    nf = $urandom_range(2, 0);
    b1 = $urandom_range(15, 0);
    b2 = (b1 + 1 + $urandom_range(14, 0)) % 16;
    if (nf >= 1) c[b1] = ~c[b1];
    if (nf == 2) c[b2] = ~c[b2];
    return c;
  endfunction

  task automatic fillBlock(input bit directed);
    logic [15:0] c;
    for (int w = 0; w < NW; w++) begin
      c = randomCodeword();
      if (directed) begin
        case (w)
          0: c = 16'h0000;
          1: c = 16'hFFFF;
          2: c = 16'h0020;
          3: c = 16'h0001;
          4: c = 16'h0028;
          default: ;
        endcase
      end
      mem[IN + 2*w]     = c[15:8];
      mem[IN + 2*w + 1] = c[7:0];
    end
    for (int a = OUT; a < OUT + 2*NW; a++) mem[a] = 8'hA5;
  endtask

  task automatic buildExpect();
    logic [15:0] r;
    exp_single = 0;
    exp_double = 0;
    for (int w = 0; w < NW; w++) begin
      r = modelDecode({mem[IN + 2*w], mem[IN + 2*w + 1]});
      exp_hi[w] = r[15:8];
      exp_lo[w] = r[7:0];
      if (r[15:14] == 2'b01) exp_single++;
      if (r[15:14] == 2'b10) exp_double++;
    end
  endtask

  // Raise start for one cycle, drop it, and begin per-cycle tracking at the
  // first read of the block.
  task automatic applyStimulus();
    buildExpect();
    @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk);
    #1 model_done = 1'b0;
    #1 start = 1'b0;
    @(posedge clk);
    #1 run_n = 0;
    tracking = 1'b1;
  endtask

  task automatic waitDone();
    for (int c = 0; c < 200 && tracking; c++) @(posedge clk);
    if (tracking) begin
      checkOutput("done_timeout", 32'd1, 32'd0);
      tracking = 1'b0;
    end
`ifdef FEC_ERR_COUNT_EN
    #1;
    checkOutput("err_single_cnt", 32'(err_single_cnt), 32'(exp_single));
    checkOutput("err_double_cnt", 32'(err_double_cnt), 32'(exp_double));
`endif
  endtask

  task automatic checkMemory();
    for (int w = 0; w < NW; w++) begin
      checkOutput($sformatf("mem_hi[%0d]", w), 32'(mem[OUT + 2*w]), 32'(exp_hi[w]));
      checkOutput($sformatf("mem_lo[%0d]", w), 32'(mem[OUT + 2*w + 1]), 32'(exp_lo[w]));
    end
  endtask

  // Per-cycle bus check: during a run, cycle n is phase n%5 of word n/5.
  always @(negedge clk) begin : compare
    int w, ph;
    logic [7:0] ea, ed;
    logic er, ew, edn;
    if (!reset) begin
      ea = 8'd0; ed = 8'd0; er = 1'b0; ew = 1'b0; edn = model_done;
      if (tracking) begin
        w  = run_n / 5;
        ph = run_n % 5;
        edn = 1'b0;
        if (run_n == 5*NW) begin
          edn = 1'b1;
        end else begin
          case (ph)
            0: begin ea = 8'(IN + 2*w);      er = 1'b1; end
            1: begin ea = 8'(IN + 2*w + 1);  er = 1'b1; end
            3: begin ea = 8'(OUT + 2*w);     ew = 1'b1; ed = exp_hi[w]; end
            4: begin ea = 8'(OUT + 2*w + 1); ew = 1'b1; ed = exp_lo[w]; end
            default: ;
          endcase
        end
      end
      checkOutput($sformatf("bus n=%0d", run_n),
                  32'({done, mem_rd_en, mem_wr_en, mem_addr, mem_wdata}),
                  32'({edn, er, ew, ea, ed}));
      if (tracking) begin
        if (run_n == 5*NW) begin
          tracking   = 1'b0;
          model_done = 1'b1;
        end else begin
          run_n++;
        end
      end
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    tracking = 1'b0;
    model_done = 1'b0;
    run_n = 0;
    start = 1'b0;
    reset = 1'b1;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    fillBlock(1'b1);
    #1;
    checkOutput("reset_bus", 32'({done, mem_rd_en, mem_wr_en, mem_addr, mem_wdata}), 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // Run 1: directed words 0..4 followed by random codewords.
    applyStimulus();
    waitDone();
    checkMemory();
    checkOutput("clean_zero_hi", 32'(mem[0]), 32'h00);
    checkOutput("clean_zero_lo", 32'(mem[1]), 32'h00);
    checkOutput("all_ones_hi",   32'(mem[2]), 32'h07);
    checkOutput("all_ones_lo",   32'(mem[3]), 32'hFF);
    checkOutput("single_b5_hi",  32'(mem[4]), 32'h40);
    checkOutput("single_b5_lo",  32'(mem[5]), 32'h00);
    checkOutput("single_p0_hi",  32'(mem[6]), 32'h40);
    checkOutput("single_p0_lo",  32'(mem[7]), 32'h00);
    checkOutput("double_hi",     32'(mem[8]), 32'h80);
    checkOutput("double_lo",     32'(mem[9]), 32'h03);

    // done must hold while start stays low; then a rerun gives the same image.
    repeat (6) @(posedge clk);
    for (int a = 0; a < 2*NW; a++) snap[a] = mem[OUT + a];
    for (int a = OUT; a < OUT + 2*NW; a++) mem[a] = 8'hA5;
    applyStimulus();
    waitDone();
    for (int a = 0; a < 2*NW; a++)
      checkOutput($sformatf("rerun[%0d]", a), 32'(mem[OUT + a]), 32'(snap[a]));

    // Abort during the high-byte write of word 3, then a full clean rerun.
    fillBlock(1'b0);
    applyStimulus();
    repeat (18) @(posedge clk);
    #2;
    checkOutput("pre_abort_wr", 32'({mem_wr_en, mem_addr}), 32'({1'b1, 8'd6}));
    tracking = 1'b0;
    model_done = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("abort_bus", 32'({done, mem_rd_en, mem_wr_en, mem_addr, mem_wdata}), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("abort_mem6", 32'(mem[6]), 32'hA5);
    checkOutput("abort_mem7", 32'(mem[7]), 32'hA5);
    checkOutput("abort_mem5", 32'(mem[5]), 32'(exp_lo[2]));
    @(posedge clk);
    #2 reset = 1'b0;
    applyStimulus();
    waitDone();
    checkMemory();

    // A couple more fully random blocks.
    for (int r = 0; r < 2; r++) begin
      fillBlock(1'b0);
      applyStimulus();
      waitDone();
      checkMemory();
    end

    repeat (3) @(posedge clk);
    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
